cnt_load_arb: RTL

CNT_LOAD_ARB -- requirements
Module: cnt_load_arb

---
 rtl/cnt_pkg.sv | 17 +
 rtl/cnt_load_arb_rr_pick.sv | 33 +++
 rtl/cnt_load_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared definitions for the counter and its load arbiter: FSM state encoding,
// default data width and a small index-wrap helper.
package cnt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cnt_load_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  int            idx;
  logic [IW-1:0] idx_v;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    idx_v  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      idx_v = IW'(idx);
      if (req[idx_v]) begin
        winner = idx_v;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_load_arb.sv
// Arbitrates N requesters onto a single counter load port: round-robin grant,
// one-cycle load strobe, then a HOLD-cycle lockout before the next grant.
module cnt_load_arb
  import cnt_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = CNT_W,
  parameter int HOLD = 3,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic           cnt_wr,
  output logic [W-1:0]   cnt_wr_data,
  input  logic [W-1:0]   cnt_out,
  output logic           busy,
  output logic [IW-1:0]  last_id,
  output logic [W-1:0]   last_val
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          cnt_wr_q, cnt_wr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] last_id_q, last_id_d;
  logic [W-1:0]  last_val_q, last_val_d;

  logic [IW-1:0] winner;
  logic          pick_valid;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    gnt_d      = '0;
    cnt_wr_d   = 1'b0;
    wr_data_d  = wr_data_q;
    last_id_d  = last_id_q;
    last_val_d = last_val_q;
    case (state_q)
      S_IDLE: begin
        // Grant-cycle outputs are computed here so they appear registered.
        if (pick_valid) begin
          state_d    = S_GRANT;
          gnt_d      = N'(1) << winner;
          cnt_wr_d   = 1'b1;
          wr_data_d  = req_data[int'(winner)*W +: W];
          last_id_d  = winner;
          last_val_d = cnt_out;
        end
      end
      S_GRANT: begin
        state_d = S_HOLD;
        ptr_d   = IW'(wrap_inc(int'(last_id_q), N));
        hold_d  = 8'(HOLD - 1);
      end
      S_HOLD: begin
        if (hold_q == 8'd0) state_d = S_IDLE;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      hold_q     <= '0;
      gnt_q      <= '0;
      cnt_wr_q   <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      last_id_q  <= '0;
      last_val_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      gnt_q      <= gnt_d;
      cnt_wr_q   <= cnt_wr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      last_id_q  <= last_id_d;
      last_val_q <= last_val_d;
    end
  end

  assign gnt         = gnt_q;
  assign cnt_wr      = cnt_wr_q;
  assign cnt_wr_data = wr_data_q;
  assign busy        = busy_q;
  assign last_id     = last_id_q;
  assign last_val    = last_val_q;

endmodule
